// File: rtl/scarv_cop_aes_wb_pkg.sv
// -----------------------------------------------------------------------------
// scarv_cop_aes_wb_pkg
// Purpose : shared types, widths and byte-merge helper for the AES writeback
//           accumulator (scarv_cop_aes_wb and scarv_cop_aes_wb_entry).
// Contents: aes_wb_state_e  - accumulator entry state encoding
//           CPR_IDX_W       - CPR register index width
//           DATA_W / BEN_W  - CPR word width and byte-enable width
//           merge_beat()    - byte-enabled merge of one AES beat into a word
// -----------------------------------------------------------------------------
package scarv_cop_aes_wb_pkg;

   localparam int unsigned CPR_IDX_W = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned BEN_W     = DATA_W / 8;

   typedef enum logic [1:0] {
      AES_WB_IDLE   = 2'd0,
      AES_WB_ACCUM  = 2'd1,
      AES_WB_COMMIT = 2'd2
   } aes_wb_state_e;

   // Replace each enabled byte of i_base with the matching byte of i_wdata.
   function automatic logic [DATA_W-1:0] merge_beat(
      input logic [DATA_W-1:0] i_base,
      input logic [BEN_W-1:0]  i_ben,
      input logic [DATA_W-1:0] i_wdata
   );
      logic [DATA_W-1:0] w_res;
      w_res = i_base;
      for (int i = 0; i < int'(BEN_W); i++) begin
         if (i_ben[i]) begin
            w_res[8*i +: 8] = i_wdata[8*i +: 8];
         end
      end
      return w_res;
   endfunction

endpackage

// File: rtl/scarv_cop_aes_wb_entry.sv
// -----------------------------------------------------------------------------
// scarv_cop_aes_wb_entry
// Purpose : one accumulator entry. Seeds from the destination's previous value
//           on the first beat, merges byte-enabled beats, and holds the merged
//           word in COMMIT until popped.
// Ports   : g_clk, g_reset   - clock, synchronous active-high reset
//           i_ivalid         - beat presented to (and accepted by) this entry
//           i_idone          - final beat of the instruction
//           i_rd_addr/prev   - destination index / current value (first beat)
//           i_ben/i_wdata    - per-beat byte enable and data
//           i_pop            - register file accepted the pending write
//           o_state          - entry state
//           o_valid          - entry holds a complete word (state == COMMIT)
//           o_addr/data/ben  - accumulated destination, word, enable union
// -----------------------------------------------------------------------------
module scarv_cop_aes_wb_entry
   import scarv_cop_aes_wb_pkg::*;
(
   input  logic                 g_clk,
   input  logic                 g_reset,
   input  logic                 i_ivalid,
   input  logic                 i_idone,
   input  logic [CPR_IDX_W-1:0] i_rd_addr,
   input  logic [DATA_W-1:0]    i_rd_prev,
   input  logic [BEN_W-1:0]     i_ben,
   input  logic [DATA_W-1:0]    i_wdata,
   input  logic                 i_pop,
   output aes_wb_state_e        o_state,
   output logic                 o_valid,
   output logic [CPR_IDX_W-1:0] o_addr,
   output logic [DATA_W-1:0]    o_data,
   output logic [BEN_W-1:0]     o_ben
);

   aes_wb_state_e        r_state;
   logic                 r_valid;
   logic [CPR_IDX_W-1:0] r_addr;
   logic [DATA_W-1:0]    r_data;
   logic [BEN_W-1:0]     r_ben;
   logic [1:0]           r_cnt;

   // Accumulator FSM; r_cnt == 3 forces commit so a missing idone cannot hang.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_state <= AES_WB_IDLE;
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ben   <= '0;
         r_cnt   <= 2'd0;
      end else begin
         unique case (r_state)
            AES_WB_IDLE: begin
               if (i_ivalid) begin
                  r_addr <= i_rd_addr;
                  r_data <= merge_beat(i_rd_prev, i_ben, i_wdata);
                  r_ben  <= i_ben;
                  if (i_idone) begin
                     r_state <= AES_WB_COMMIT;
                     r_valid <= 1'b1;
                     r_cnt   <= 2'd0;
                  end else begin
                     r_state <= AES_WB_ACCUM;
                     r_cnt   <= 2'd1;
                  end
               end
            end
            AES_WB_ACCUM: begin
               if (!i_ivalid) begin
                  // Flush: drop the partial word, nothing is written.
                  r_state <= AES_WB_IDLE;
                  r_cnt   <= 2'd0;
               end else begin
                  r_data <= merge_beat(r_data, i_ben, i_wdata);
                  r_ben  <= r_ben | i_ben;
                  if (i_idone || (r_cnt == 2'd3)) begin
                     r_state <= AES_WB_COMMIT;
                     r_valid <= 1'b1;
                     r_cnt   <= 2'd0;
                  end else begin
                     r_cnt <= r_cnt + 2'd1;
                  end
               end
            end
            AES_WB_COMMIT: begin
               if (i_pop) begin
                  r_state <= AES_WB_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= AES_WB_IDLE;
               r_valid <= 1'b0;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

   assign o_state = r_state;
   assign o_valid = r_valid;
   assign o_addr  = r_addr;
   assign o_data  = r_data;
   assign o_ben   = r_ben;

endmodule

// File: rtl/scarv_cop_aes_wb.sv
// -----------------------------------------------------------------------------
// scarv_cop_aes_wb
// Purpose : writeback accumulator behind the co-processor AES unit. Merges the
//           per-beat byte-enabled results into one CPR word and commits it over
//           a valid/ready handshake, holding dispatch while it cannot accept.
// Macro   : SCARV_COP_AES_WB_SKID_EN - two entries so a new instruction can
//           accumulate while the previous one waits to commit (in order).
// Ports   : g_clk, g_reset          - clock, synchronous active-high reset
//           aes_ivalid, aes_idone   - AES beat valid / final beat
//           aes_rd_addr, aes_rd_prev- destination index / current value
//           aes_cpr_rd_ben/_wdata   - per-beat byte enable / data
//           aes_hold                - dispatch must not issue or advance
//           wb_valid/wb_ready       - commit handshake to the CPR file
//           wb_addr/wb_data/wb_ben  - committed index, word, byte enables
// -----------------------------------------------------------------------------
module scarv_cop_aes_wb
   import scarv_cop_aes_wb_pkg::*;
(
   input  logic                 g_clk,
   input  logic                 g_reset,
   input  logic                 aes_ivalid,
   input  logic                 aes_idone,
   input  logic [CPR_IDX_W-1:0] aes_rd_addr,
   input  logic [DATA_W-1:0]    aes_rd_prev,
   input  logic [BEN_W-1:0]     aes_cpr_rd_ben,
   input  logic [DATA_W-1:0]    aes_cpr_rd_wdata,
   output logic                 aes_hold,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [CPR_IDX_W-1:0] wb_addr,
   output logic [DATA_W-1:0]    wb_data,
   output logic [BEN_W-1:0]     wb_ben
);

`ifdef SCARV_COP_AES_WB_SKID_EN

   aes_wb_state_e        w_state [2];
   logic                 w_valid [2];
   logic [CPR_IDX_W-1:0] w_addr  [2];
   logic [DATA_W-1:0]    w_data  [2];
   logic [BEN_W-1:0]     w_ben   [2];
   logic [1:0]           w_ivalid;
   logic [1:0]           w_pop;
   logic                 w_sel;
   logic                 r_head;

   // Beats go to the entry already accumulating, else to a free entry
   // (the head when both are free, so commit order follows issue order).
   always_comb begin
      w_sel = r_head;
      if (w_state[0] == AES_WB_ACCUM) begin
         w_sel = 1'b0;
      end else if (w_state[1] == AES_WB_ACCUM) begin
         w_sel = 1'b1;
      end else if (w_state[r_head] != AES_WB_IDLE) begin
         w_sel = ~r_head;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_entry
      assign w_ivalid[g] = aes_ivalid && !aes_hold && (w_sel == 1'(g));
      assign w_pop[g]    = wb_ready && (r_head == 1'(g));

      scarv_cop_aes_wb_entry u_entry (
         .g_clk     (g_clk),
         .g_reset   (g_reset),
         .i_ivalid  (w_ivalid[g]),
         .i_idone   (aes_idone),
         .i_rd_addr (aes_rd_addr),
         .i_rd_prev (aes_rd_prev),
         .i_ben     (aes_cpr_rd_ben),
         .i_wdata   (aes_cpr_rd_wdata),
         .i_pop     (w_pop[g]),
         .o_state   (w_state[g]),
         .o_valid   (w_valid[g]),
         .o_addr    (w_addr[g]),
         .o_data    (w_data[g]),
         .o_ben     (w_ben[g])
      );
   end

   // Head points at the oldest entry; it advances on each handshake.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_head <= 1'b0;
      end else if (w_valid[r_head] && wb_ready) begin
         r_head <= ~r_head;
      end
   end

   assign aes_hold = (w_state[0] == AES_WB_COMMIT) && (w_state[1] == AES_WB_COMMIT);
   assign wb_valid = w_valid[r_head];
   assign wb_addr  = w_addr[r_head];
   assign wb_data  = w_data[r_head];
   assign wb_ben   = w_ben[r_head];

`else

   aes_wb_state_e w_state;
   logic          w_ivalid;

   // Beats presented while committing are dropped.
   assign w_ivalid = aes_ivalid && !aes_hold;

   scarv_cop_aes_wb_entry u_entry (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .i_ivalid  (w_ivalid),
      .i_idone   (aes_idone),
      .i_rd_addr (aes_rd_addr),
      .i_rd_prev (aes_rd_prev),
      .i_ben     (aes_cpr_rd_ben),
      .i_wdata   (aes_cpr_rd_wdata),
      .i_pop     (wb_ready),
      .o_state   (w_state),
      .o_valid   (wb_valid),
      .o_addr    (wb_addr),
      .o_data    (wb_data),
      .o_ben     (wb_ben)
   );

   assign aes_hold = (w_state == AES_WB_COMMIT);

`endif

endmodule

// File: tb/tb_scarv_cop_aes_wb.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_aes_wb
// Purpose : self-checking bench for scarv_cop_aes_wb. Stimulus pushes expected
//           commits into a queue; a monitor pops and compares on every
//           wb_valid && wb_ready handshake. Cycle-timed checks cover latency,
//           hold, stability under back-pressure, flush and reset.
// Macro   : SCARV_COP_AES_WB_SKID_EN selects the two-entry expectations.
// -----------------------------------------------------------------------------
module tb_scarv_cop_aes_wb;
   import scarv_cop_aes_wb_pkg::*;

`ifdef SCARV_COP_AES_WB_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct {
      logic [CPR_IDX_W-1:0] addr;
      logic [DATA_W-1:0]    data;
      logic [BEN_W-1:0]     ben;
   } exp_t;

   logic                 g_clk = 1'b0;
   logic                 g_reset;
   logic                 aes_ivalid;
   logic                 aes_idone;
   logic [CPR_IDX_W-1:0] aes_rd_addr;
   logic [DATA_W-1:0]    aes_rd_prev;
   logic [BEN_W-1:0]     aes_cpr_rd_ben;
   logic [DATA_W-1:0]    aes_cpr_rd_wdata;
   logic                 aes_hold;
   logic                 wb_valid;
   logic                 wb_ready;
   logic [CPR_IDX_W-1:0] wb_addr;
   logic [DATA_W-1:0]    wb_data;
   logic [BEN_W-1:0]     wb_ben;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];
   logic exp_hold_commit;

   scarv_cop_aes_wb dut (
      .g_clk            (g_clk),
      .g_reset          (g_reset),
      .aes_ivalid       (aes_ivalid),
      .aes_idone        (aes_idone),
      .aes_rd_addr      (aes_rd_addr),
      .aes_rd_prev      (aes_rd_prev),
      .aes_cpr_rd_ben   (aes_cpr_rd_ben),
      .aes_cpr_rd_wdata (aes_cpr_rd_wdata),
      .aes_hold         (aes_hold),
      .wb_valid         (wb_valid),
      .wb_ready         (wb_ready),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data),
      .wb_ben           (wb_ben)
   );

   always #5 g_clk = ~g_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.ben  = b;
      sb_q.push_back(e);
   endtask

   // Present one beat for one cycle.
   task automatic beat(input logic idone, input logic [3:0] rd, input logic [31:0] prev,
                       input logic [3:0] ben, input logic [31:0] wdata);
      aes_ivalid       = 1'b1;
      aes_idone        = idone;
      aes_rd_addr      = rd;
      aes_rd_prev      = prev;
      aes_cpr_rd_ben   = ben;
      aes_cpr_rd_wdata = wdata;
      @(posedge g_clk);
      #1;
   endtask

   // Idle cycles, checking wb_valid each cycle.
   task automatic idle(input int n, input logic exp_valid, input string name);
      for (int i = 0; i < n; i++) begin
         aes_ivalid     = 1'b0;
         aes_idone      = 1'b0;
         aes_cpr_rd_ben = '0;
         @(negedge g_clk);
         check(name, 32'(wb_valid), 32'(exp_valid));
         @(posedge g_clk);
         #1;
      end
   endtask

   // Scoreboard monitor: compare every accepted write against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge g_clk);
         if (!g_reset && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_write", 32'(wb_addr), 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               check("sb_addr", 32'(wb_addr), 32'(e.addr));
               check("sb_data", wb_data, e.data);
               check("sb_ben",  32'(wb_ben), 32'(e.ben));
            end
         end
      end
   end

   initial begin
      exp_hold_commit  = !SKID;
      g_reset          = 1'b1;
      aes_ivalid       = 1'b0;
      aes_idone        = 1'b0;
      aes_rd_addr      = '0;
      aes_rd_prev      = '0;
      aes_cpr_rd_ben   = '0;
      aes_cpr_rd_wdata = '0;
      wb_ready         = 1'b1;   // ready while nothing is valid must be harmless
      repeat (2) @(posedge g_clk);
      #1;
      g_reset = 1'b0;

      // Reset state
      @(negedge g_clk);
      check("rst_valid", 32'(wb_valid), 32'd0);
      check("rst_hold",  32'(aes_hold), 32'd0);
      check("rst_addr",  32'(wb_addr),  32'd0);
      check("rst_data",  wb_data,       32'd0);
      check("rst_ben",   32'(wb_ben),   32'd0);
      @(posedge g_clk);
      #1;

      // Full 4-beat op: beats T0..T3, wb_valid in T4
      push(4'd5, 32'h6363_6363, 4'hF);
      beat(1'b0, 4'd5, 32'hDEAD_BEEF, 4'b0001, 32'h6363_6363);
      beat(1'b0, 4'd5, 32'hDEAD_BEEF, 4'b0010, 32'h6363_6363);
      beat(1'b0, 4'd5, 32'hDEAD_BEEF, 4'b0100, 32'h6363_6363);
      beat(1'b1, 4'd5, 32'hDEAD_BEEF, 4'b1000, 32'h6363_6363);
      aes_ivalid = 1'b0;
      aes_idone  = 1'b0;
      @(negedge g_clk);
      check("op1_valid_T4", 32'(wb_valid), 32'd1);
      check("op1_hold_T4",  32'(aes_hold), 32'(exp_hold_commit));
      @(posedge g_clk);
      #1;

      // Partial enables, first beat in T5 right after the handshake
      push(4'd9, 32'h11BB_33AA, 4'b0101);
      beat(1'b0, 4'd9, 32'h1122_3344, 4'b0001, 32'h0000_00AA);
      beat(1'b0, 4'd9, 32'h1122_3344, 4'b0000, 32'hFFFF_FFFF);
      beat(1'b0, 4'd9, 32'h1122_3344, 4'b0100, 32'h00BB_0000);
      beat(1'b1, 4'd9, 32'h1122_3344, 4'b0000, 32'hFFFF_FFFF);
      idle(1, 1'b1, "op2_valid");

      // Back-pressure: outputs stable and hold asserted for 5 stalled cycles
      wb_ready = 1'b0;
      push(4'd2, 32'hCAFE_F00D, 4'hF);
      beat(1'b1, 4'd2, 32'h0000_0000, 4'hF, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) begin
         if (!SKID) begin
            aes_ivalid = 1'b1; aes_idone = 1'b1; aes_rd_addr = 4'd4;
            aes_rd_prev = '0; aes_cpr_rd_ben = 4'b0001; aes_cpr_rd_wdata = 32'h0000_0077;
         end else begin
            aes_ivalid = 1'b0; aes_idone = 1'b0;
         end
         @(negedge g_clk);
         check("stall_valid", 32'(wb_valid), 32'd1);
         check("stall_hold",  32'(aes_hold), 32'(exp_hold_commit));
         check("stall_addr",  32'(wb_addr),  32'd2);
         check("stall_data",  wb_data,       32'hCAFE_F00D);
         check("stall_ben",   32'(wb_ben),   32'hF);
         @(posedge g_clk);
         #1;
      end
      wb_ready = 1'b1;
      @(negedge g_clk);
      check("hs_valid", 32'(wb_valid), 32'd1);
      if (!SKID) push(4'd4, 32'h0000_0077, 4'b0001);
      @(posedge g_clk);
      #1;
      @(negedge g_clk);
      check("post_hs_valid", 32'(wb_valid), 32'd0);
      check("post_hs_hold",  32'(aes_hold), 32'd0);
      @(posedge g_clk);
      #1;
      idle(1, !SKID, "late_beat_commit");

      // Flush after two beats: no write, next op reseeds from its own prev
      beat(1'b0, 4'd6, 32'hAAAA_AAAA, 4'hF, 32'h1234_5678);
      beat(1'b0, 4'd6, 32'hAAAA_AAAA, 4'h0, 32'h0000_0000);
      idle(3, 1'b0, "flush_no_write");
      push(4'd6, 32'h5555_55EE, 4'b0001);
      beat(1'b1, 4'd6, 32'h5555_5555, 4'b0001, 32'h0000_00EE);
      idle(1, 1'b1, "post_flush_valid");

      // Synchronous reset in T2 of an op
      beat(1'b0, 4'd8, 32'h0000_0000, 4'hF, 32'h9999_9999);
      beat(1'b0, 4'd8, 32'h0000_0000, 4'h0, 32'h0000_0000);
      g_reset = 1'b1;
      beat(1'b0, 4'd8, 32'h0000_0000, 4'h0, 32'h0000_0000);
      g_reset    = 1'b0;
      aes_ivalid = 1'b0;
      @(negedge g_clk);
      check("rst_mid_valid", 32'(wb_valid), 32'd0);
      check("rst_mid_hold",  32'(aes_hold), 32'd0);
      check("rst_mid_data",  wb_data,       32'd0);
      check("rst_mid_ben",   32'(wb_ben),   32'd0);
      @(posedge g_clk);
      #1;
      idle(3, 1'b0, "rst_mid_no_write");

      // Missing idone: the fourth beat forces the commit
      push(4'hF, 32'h0403_0201, 4'hF);
      beat(1'b0, 4'hF, 32'h0000_0000, 4'b0001, 32'h0000_0001);
      beat(1'b0, 4'hF, 32'h0000_0000, 4'b0010, 32'h0000_0200);
      beat(1'b0, 4'hF, 32'h0000_0000, 4'b0100, 32'h0003_0000);
      beat(1'b0, 4'hF, 32'h0000_0000, 4'b1000, 32'h0400_0000);
      idle(1, 1'b1, "forced_commit_valid");
      idle(1, 1'b0, "forced_commit_done");

`ifdef SCARV_COP_AES_WB_SKID_EN
      // Back-to-back ops with no idle cycle: commits in T4 and T8, no hold
      push(4'd3, 32'hA1A2_A3A4, 4'hF);
      push(4'd7, 32'hFFFF_BEEF, 4'b0011);
      for (int i = 0; i < 8; i++) begin
         aes_ivalid  = 1'b1;
         aes_idone   = (i == 3) || (i == 7);
         aes_rd_addr = (i < 4) ? 4'd3 : 4'd7;
         aes_rd_prev = (i < 4) ? 32'h0000_0000 : 32'hFFFF_FFFF;
         if (i < 4) begin
            aes_cpr_rd_ben   = 4'(1 << i);
            aes_cpr_rd_wdata = 32'hA1A2_A3A4;
         end else begin
            aes_cpr_rd_ben   = (i == 7) ? 4'b0011 : 4'b0000;
            aes_cpr_rd_wdata = 32'h0000_BEEF;
         end
         @(negedge g_clk);
         check("skid_hold",  32'(aes_hold), 32'd0);
         check("skid_valid", 32'(wb_valid), 32'(i == 4));
         @(posedge g_clk);
         #1;
      end
      idle(1, 1'b1, "skid_valid_T8");
`endif

      idle(2, 1'b0, "drain");
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scarv_cop_aes_wb.md
# scarv_cop_aes_wb

Writeback accumulator sitting directly downstream of the co-processor AES functional unit. It merges the unit's per-cycle byte-enabled partial results (one byte per beat over the 4-beat AES sequence) into a single 32-bit CPR word. It then presents one full-word write to the CPR register file over a valid/ready handshake. While a commit is pending it back-pressures dispatch so no AES beat is lost.

## Interface
- No parameters.
- g_clk  in  1  clock; all state updates on rising edge
- g_reset  in  1  synchronous, active-high reset
- aes_ivalid  in  1  AES instruction valid (same signal driving the AES unit)
- aes_idone  in  1  AES unit final beat
- aes_rd_addr  in  4  destination CPR index, sampled on first beat
- aes_rd_prev  in  32  current value of destination CPR, sampled on first beat
- aes_cpr_rd_ben  in  4  per-beat byte enable from AES unit
- aes_cpr_rd_wdata  in  32  per-beat write data from AES unit
- aes_hold  out  1  dispatch must not issue or advance an AES instruction
- wb_valid  out  1  full-word write pending
- wb_ready  in  1  register file accepts write
- wb_addr  out  4  destination CPR index
- wb_data  out  32  merged word
- wb_ben  out  4  OR of all beat enables seen for this instruction

## Operation
- States: IDLE, ACCUM, COMMIT.
- IDLE:
  - On aes_ivalid && !aes_hold: latch aes_rd_addr.
  - Seed data_q = aes_rd_prev, then merge the beat: byte i = aes_cpr_rd_ben[i] ? wdata byte i : seed byte i.
  - ben_q = aes_cpr_rd_ben.
  - Go to ACCUM, or to COMMIT if aes_idone is high in the same cycle.
- ACCUM:
  - Each cycle with aes_ivalid: merge the beat into data_q and OR it into ben_q.
  - If aes_idone: merge and go to COMMIT.
  - If aes_ivalid drops before aes_idone (flush): discard and return to IDLE with no write.
- COMMIT: wb_valid=1. On wb_ready go to IDLE. wb_addr, wb_data and wb_ben stay stable while wb_valid && !wb_ready.
- aes_hold = (state==COMMIT) in the base build.
- A beat with ben=0 is legal: no bytes change, beat count still advances.
- Beat counter (2 bits) increments per accepted beat and wraps 3→0 on commit. If it reaches 3 without aes_idone, the block treats the next beat as idone-equivalent (forced commit). This prevents a hung accumulator.

## Timing
- Reset values: state=IDLE, wb_valid=0, wb_addr=0, wb_data=0, wb_ben=0, aes_hold=0, beat counter=0.
- Standard 4-beat AES op with first beat in cycle T0 and idone in T3: wb_valid rises in T4. With wb_ready high in T4, the block returns to IDLE in T5 and a new first beat is accepted in T5.
- wb_ready asserted while wb_valid=0 is ignored.
- g_reset mid-ACCUM or mid-COMMIT: returns to IDLE the next edge, the pending write is dropped, and wb_valid=0.
- aes_ivalid and aes_idone in the same cycle as a COMMIT handshake (base build): aes_hold is high, so dispatch must not present that beat. A beat presented anyway is ignored.

## Configuration
- SCARV_COP_AES_WB_SKID_EN defined:
  - Adds a second accumulator entry so the next instruction can accumulate while the previous one waits in COMMIT.
  - Commits are in order, oldest first.
  - aes_hold = (COMMIT entry occupied && second entry reached idone).
  - Back-to-back ops with wb_ready always high sustain one commit per 4 cycles with zero idle cycles.
- Undefined: single entry; aes_hold = (state==COMMIT).

## Structure
- Shared package / common header holds:
  - state encoding constants AES_WB_IDLE=2'd0, AES_WB_ACCUM=2'd1, AES_WB_COMMIT=2'd2;
  - the CPR index width (4).
- One natural sub-module, scarv_cop_aes_wb_entry: one accumulator (addr, data, ben, beat count, merge logic). It is instantiated once, or twice under SCARV_COP_AES_WB_SKID_EN.

## Test plan
- sub.enc, rs1=rs2=0, aes_rd_prev=0xDEADBEEF, rd=5, four beats with ben 0001/0010/0100/1000 -> one write: wb_addr=5, wb_data=0x63636363, wb_ben=4'hF, wb_valid in T4.
- Partial enables: only beats with ben 0001 and 0100 carry data 0x000000AA and 0x00BB0000, aes_rd_prev=0x11223344 -> wb_data=0x11BB33AA, wb_ben=4'b0101.
- wb_ready held low 5 cycles after wb_valid -> wb_data, wb_addr and wb_ben stable, aes_hold=1 throughout, and a new aes_ivalid is not accepted until the cycle after the handshake.
- Flush: aes_ivalid drops after beat 2 with no idone -> no wb_valid; the next instruction starts from a fresh aes_rd_prev seed.
- g_reset in T2 of an op -> wb_valid=0 and state IDLE at T3; the op's data never appears on wb_data.
- SKID_EN build: two back-to-back ops to rd 3 then rd 7 with wb_ready=1 -> commits in T4 (rd 3) and T8 (rd 7), aes_hold never asserted.
